pico_bus_arbiter: RTL and testbench



---
 rtl/pico_bus_arbiter_pkg.sv | 24 ++
 rtl/pico_bus_arbiter_rr_pick.sv | 37 +++
 rtl/pico_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_pico_bus_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pico_bus_arbiter_pkg
// Description : Shared definitions for the pico bus arbiter: FSM state
//               encoding, default timeout read data, round-robin helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pico_bus_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Read data handed back to a master whose slave access timed out
    localparam logic [31:0] c_err_rdata_default = 32'hDEADBEEF;

    // Index reached by stepping 'offset' places after 'base', modulo n
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pico_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : pico_bus_arbiter_rr_pick
// Description : Combinational round-robin selector. Scans the request vector
//               starting one past the last grant and wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_bus_arbiter_rr_pick
    import pico_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] w_idx;

    // First requester after last_grant wins; last_grant itself is checked last
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'(rr_index(int'(last_grant), k, NUM_REQ));
            if (!any_req && req[w_idx]) begin
                winner  = w_idx;
                any_req = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pico_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pico_bus_arbiter
// Description : Round-robin arbiter connecting NUM_MASTERS native-bus masters
//               to one slave, with a per-transfer wait timeout that completes
//               the access with an error flag and fixed read data.
// Revision    : 1.0 - initial release
// ============================================================================
module pico_bus_arbiter
    import pico_bus_arbiter_pkg::*;
#(
    parameter int          NUM_MASTERS = 2,
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_RDATA   = c_err_rdata_default
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_MASTERS-1:0]               m_valid,
    input  logic [NUM_MASTERS*ADDR_W-1:0]        m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]        m_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]    m_wstrb,
    output logic [NUM_MASTERS-1:0]               m_ready,
    output logic [NUM_MASTERS-1:0]               m_err,
    output logic [DATA_W-1:0]                    m_rdata,
    output logic                                 s_valid,
    output logic [ADDR_W-1:0]                    s_addr,
    output logic [DATA_W-1:0]                    s_wdata,
    output logic [DATA_W/8-1:0]                  s_wstrb,
    input  logic                                 s_ready,
    input  logic [DATA_W-1:0]                    s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0]       grant_idx,
    output logic                                 busy
);

    localparam int                c_idx_w     = $clog2(NUM_MASTERS);
    localparam int                c_cnt_w     = $clog2(TIMEOUT + 1);
    localparam int                c_strb_w    = DATA_W / 8;
    localparam logic [DATA_W-1:0] c_err_rdata = DATA_W'(ERR_RDATA);

    arb_state_t           r_state, w_state_nxt;
    logic [c_idx_w-1:0]   r_grant, w_grant_nxt;
    logic [c_idx_w-1:0]   r_last,  w_last_nxt;
    logic [c_cnt_w-1:0]   r_cnt,   w_cnt_nxt;
    logic [c_idx_w-1:0]   w_winner;
    logic                 w_any;

    logic [ADDR_W-1:0]    w_addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]    w_wdata_arr [NUM_MASTERS];
    logic [c_strb_w-1:0]  w_wstrb_arr [NUM_MASTERS];

    // Split the flattened request buses into per-master slices
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = m_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = m_wdata[gi*DATA_W +: DATA_W];
        assign w_wstrb_arr[gi] = m_wstrb[gi*c_strb_w +: c_strb_w];
    end

    pico_bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (c_idx_w)
    ) u_rr_pick (
        .req        (m_valid),
        .last_grant (r_last),
        .winner     (w_winner),
        .any_req    (w_any)
    );

    // Address and write data follow the owner; strobes are gated to BUSY
    assign s_addr    = w_addr_arr[r_grant];
    assign s_wdata   = w_wdata_arr[r_grant];
    assign grant_idx = r_grant;

    // State register; reset makes master 0 the first winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_last  <= c_idx_w'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state and output decode; abort beats completion, completion beats timeout
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        s_valid     = 1'b0;
        s_wstrb     = '0;
        m_ready     = '0;
        m_err       = '0;
        m_rdata     = s_rdata;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_winner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy    = 1'b1;
                s_valid = 1'b1;
                s_wstrb = w_wstrb_arr[r_grant];
                if (!m_valid[r_grant]) begin
                    w_state_nxt = ST_IDLE;
                end else if (s_ready) begin
                    m_ready[r_grant] = 1'b1;
                    w_last_nxt       = r_grant;
                    w_state_nxt      = ST_IDLE;
                end else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
                    m_ready[r_grant] = 1'b1;
                    m_err[r_grant]   = 1'b1;
                    m_rdata          = c_err_rdata;
                    w_last_nxt       = r_grant;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pico_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pico_bus_arbiter
// Description : Self-checking bench for pico_bus_arbiter (3 masters,
//               TIMEOUT=4). Expected completions are queued as stimulus is
//               driven and popped when the DUT raises m_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pico_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    m_err;
    logic [DW-1:0]   m_rdata;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_ready;
    logic [DW-1:0]   s_rdata;
    logic [IW-1:0]   grant_idx;
    logic            busy;

    typedef struct {
        int            master;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pico_bus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TO),
        .ERR_RDATA   (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [SW-1:0] s);
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_wstrb[i*SW +: SW] = s;
    endtask

    task automatic expect_done(input int m, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.master = m;
        e.rdata  = rd;
        e.err    = err;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every m_ready pulse must match the oldest queued completion
    always @(negedge clk) begin : p_mon
        exp_t e;
        if (!reset) begin
            if ((m_err & ~m_ready) != '0)
                check_eq("err_without_ready", 64'(m_err & ~m_ready), 64'(0));
            if (m_ready != '0) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_ready", 64'(m_ready), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    check_eq("sb_ready", 64'(m_ready), 64'(1) << e.master);
                    check_eq("sb_grant", 64'(grant_idx), 64'(e.master));
                    check_eq("sb_rdata", 64'(m_rdata), 64'(e.rdata));
                    check_eq("sb_err", 64'(m_err), e.err ? (64'(1) << e.master) : 64'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",    64'(busy),      64'(0));
        check_eq("rst_s_valid", 64'(s_valid),   64'(0));
        check_eq("rst_m_ready", 64'(m_ready),   64'(0));
        check_eq("rst_m_err",   64'(m_err),     64'(0));
        check_eq("rst_grant",   64'(grant_idx), 64'(0));
        check_eq("rst_s_wstrb", 64'(s_wstrb),   64'(0));
        reset = 1'b0;
        cyc();
        check_eq("idle_no_req", 64'(busy), 64'(0));

        // Single master read, slave ready on 3rd BUSY cycle
        set_master(0, 32'h0002_0000, 32'h0, 4'h0);
        m_valid = 3'b001;
        #1;
        check_eq("t1_idle_s_valid", 64'(s_valid), 64'(0));
        expect_done(0, 32'h1234_5678, 1'b0);
        cyc(); #1;
        check_eq("t1_b1_s_valid", 64'(s_valid),   64'(1));
        check_eq("t1_b1_grant",   64'(grant_idx), 64'(0));
        check_eq("t1_b1_addr",    64'(s_addr),    64'h0002_0000);
        check_eq("t1_b1_ready",   64'(m_ready),   64'(0));
        cyc(); #1;
        check_eq("t1_b2_ready",   64'(m_ready),   64'(0));
        cyc();
        s_ready = 1'b1;
        s_rdata = 32'h1234_5678;
        #1;
        check_eq("t1_b3_ready",   64'(m_ready),   64'(1));
        cyc();
        s_ready = 1'b0;
        m_valid = '0;
        #1;
        check_eq("t1_back_idle",  64'(busy),      64'(0));

        // Master 1 write with partial strobes
        set_master(1, 32'h0000_1000, 32'hAABB_CCDD, 4'b0011);
        m_valid = 3'b010;
        #1;
        check_eq("t2_idle_wstrb", 64'(s_wstrb), 64'(0));
        expect_done(1, 32'h55AA_0001, 1'b0);
        cyc(); #1;
        check_eq("t2_b1_wstrb", 64'(s_wstrb),   64'(4'b0011));
        check_eq("t2_b1_wdata", 64'(s_wdata),   64'hAABB_CCDD);
        check_eq("t2_b1_grant", 64'(grant_idx), 64'(1));
        cyc();
        s_ready = 1'b1;
        s_rdata = 32'h55AA_0001;
        #1;
        check_eq("t2_b2_wstrb", 64'(s_wstrb),   64'(4'b0011));
        check_eq("t2_b2_wdata", 64'(s_wdata),   64'hAABB_CCDD);
        cyc();
        s_ready = 1'b0;
        m_valid = '0;

        // Reset in 2nd BUSY cycle of master 2's transfer (last grant was 1)
        set_master(0, 32'h0000_0100, 32'h0, 4'h0);
        set_master(2, 32'h0000_0200, 32'h0, 4'h0);
        m_valid = 3'b101;
        cyc(); #1;
        check_eq("rst_mid_grant2", 64'(grant_idx), 64'(2));
        cyc(); #1;
        check_eq("rst_mid_pre_valid", 64'(s_valid), 64'(1));
        reset = 1'b1;
        #1;
        check_eq("rst_mid_s_valid", 64'(s_valid),   64'(0));
        check_eq("rst_mid_busy",    64'(busy),      64'(0));
        check_eq("rst_mid_grant",   64'(grant_idx), 64'(0));
        check_eq("rst_mid_ready",   64'(m_ready),   64'(0));
        cyc();
        reset   = 1'b0;
        m_valid = 3'b111;
        s_ready = 1'b1;

        // Contention: all masters request, slave ready in first BUSY cycle
        for (int k = 0; k < 6; k++) begin
            s_rdata = 32'hC0DE_0000 + 32'(k);
            expect_done(k % 3, 32'hC0DE_0000 + 32'(k), 1'b0);
            #1;
            check_eq("cont_idle", 64'(busy), 64'(0));
            cyc(); #1;
            check_eq("cont_grant", 64'(grant_idx), 64'(k % 3));
            check_eq("cont_busy",  64'(busy),      64'(1));
            cyc();
        end
        m_valid = '0;
        s_ready = 1'b0;

        // Timeout: master 1, slave never ready
        set_master(1, 32'h0000_2000, 32'h0, 4'h0);
        s_rdata = 32'h1111_1111;
        m_valid = 3'b010;
        expect_done(1, 32'hDEAD_BEEF, 1'b1);
        for (int b = 1; b < TO; b++) begin
            cyc(); #1;
            check_eq("to_wait_ready", 64'(m_ready), 64'(0));
        end
        cyc(); #1;
        check_eq("to_ready", 64'(m_ready), 64'(3'b010));
        check_eq("to_err",   64'(m_err),   64'(3'b010));
        check_eq("to_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        cyc();
        m_valid = '0;
        #1;
        check_eq("to_idle", 64'(busy), 64'(0));

        // s_ready on the timeout cycle: normal completion wins
        set_master(2, 32'h0000_3000, 32'h0, 4'h0);
        m_valid = 3'b100;
        expect_done(2, 32'hCAFE_0004, 1'b0);
        for (int b = 1; b < TO; b++) cyc();
        cyc();
        s_ready = 1'b1;
        s_rdata = 32'hCAFE_0004;
        #1;
        check_eq("sim_ready", 64'(m_ready), 64'(3'b100));
        check_eq("sim_err",   64'(m_err),   64'(0));
        cyc();
        s_ready = 1'b0;
        m_valid = '0;

        // Master abort leaves last grant (2) unchanged
        set_master(0, 32'h0000_4000, 32'h0, 4'h0);
        m_valid = 3'b001;
        cyc(); #1;
        check_eq("ab_grant", 64'(grant_idx), 64'(0));
        m_valid = '0;
        #1;
        check_eq("ab_ready", 64'(m_ready), 64'(0));
        cyc(); #1;
        check_eq("ab_idle", 64'(busy), 64'(0));
        m_valid = 3'b101;
        s_rdata = 32'h0A0A_0A0A;
        expect_done(0, 32'h0A0A_0A0A, 1'b0);
        cyc();
        s_ready = 1'b1;
        #1;
        check_eq("ab_next_grant", 64'(grant_idx), 64'(0));
        cyc();
        s_ready = 1'b0;
        m_valid = '0;

        repeat (3) cyc();
        check_eq("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
